id_ex_stage: RTL

ID/EX pipeline stage of the five-stage MIPS datapath. Sits directly downstream of the instruction decoder/controller. Each cycle it captures the decoded control word, register operands and immediate into EX-stage registers, sanitises don't-care widths, and detects load-use hazards. On a hazard or a branch flush it inserts a bubble.

---
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional event counters are enabled by defining ID_EX_STATS_EN.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int STAT_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ID_Valid,
    input  logic              Hold,
    input  logic              Flush,
    input  logic              RegDst,
    input  logic              ALUSrc0,
    input  logic              R_Enable,
    input  logic              W_Enable,
    input  logic              MemToReg,
    input  logic              RegWrite,
    input  logic [1:0]        ALUSrc1,
    input  logic [1:0]        R_Width,
    input  logic [1:0]        W_Width,
    input  logic [DATA_W-1:0] PCPlus4,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    input  logic [DATA_W-1:0] SignExt,
    input  logic [4:0]        Rs,
    input  logic [4:0]        Rt,
    input  logic [4:0]        Rd,
    input  logic [4:0]        Shamt,
    input  logic [5:0]        Funct,
    output logic              E_Valid,
    output logic              E_RegDst,
    output logic              E_ALUSrc0,
    output logic              E_R_Enable,
    output logic              E_W_Enable,
    output logic              E_MemToReg,
    output logic              E_RegWrite,
    output logic [1:0]        E_ALUSrc1,
    output logic [1:0]        E_R_Width,
    output logic [1:0]        E_W_Width,
    output logic [DATA_W-1:0] E_PCPlus4,
    output logic [DATA_W-1:0] E_ReadData1,
    output logic [DATA_W-1:0] E_ReadData2,
    output logic [DATA_W-1:0] E_SignExt,
    output logic [4:0]        E_Rs,
    output logic [4:0]        E_Rt,
    output logic [4:0]        E_Rd,
    output logic [4:0]        E_Shamt,
    output logic [5:0]        E_Funct,
    output logic              HazardStall,
    output logic [STAT_W-1:0] StallCount,
    output logic [STAT_W-1:0] FlushCount
);

    logic bubble;

    // Both source fields are compared regardless of opcode; spurious stalls are harmless.
    assign HazardStall = ID_Valid & E_Valid & E_R_Enable & (E_Rt != 5'd0) &
                         ((E_Rt == Rs) | (E_Rt == Rt));
    assign bubble = Flush | HazardStall;

    // Operands carry no meaning in a bubble, so they simply load whenever not held.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            E_PCPlus4   <= '0;
            E_ReadData1 <= '0;
            E_ReadData2 <= '0;
            E_SignExt   <= '0;
        end else if (!Hold) begin
            E_PCPlus4   <= PCPlus4;
            E_ReadData1 <= ReadData1;
            E_ReadData2 <= ReadData2;
            E_SignExt   <= SignExt;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            E_Valid    <= 1'b0;
            E_RegDst   <= 1'b0;
            E_ALUSrc0  <= 1'b0;
            E_R_Enable <= 1'b0;
            E_W_Enable <= 1'b0;
            E_MemToReg <= 1'b0;
            E_RegWrite <= 1'b0;
            E_ALUSrc1  <= 2'b00;
            E_R_Width  <= 2'b00;
            E_W_Width  <= 2'b00;
            E_Rs       <= 5'd0;
            E_Rt       <= 5'd0;
            E_Rd       <= 5'd0;
            E_Shamt    <= 5'd0;
            E_Funct    <= 6'd0;
        end else if (!Hold) begin
            if (bubble) begin
                E_Valid    <= 1'b0;
                E_RegDst   <= 1'b0;
                E_ALUSrc0  <= 1'b0;
                E_R_Enable <= 1'b0;
                E_W_Enable <= 1'b0;
                E_MemToReg <= 1'b0;
                E_RegWrite <= 1'b0;
                E_ALUSrc1  <= 2'b00;
                E_R_Width  <= 2'b00;
                E_W_Width  <= 2'b00;
                E_Rs       <= 5'd0;
                E_Rt       <= 5'd0;
                E_Rd       <= 5'd0;
                E_Shamt    <= 5'd0;
                E_Funct    <= 6'd0;
            end else begin
                // Ternaries keep X on a disabled width or invalid slot out of EX.
                E_Valid    <= ID_Valid;
                E_RegDst   <= ID_Valid ? RegDst   : 1'b0;
                E_ALUSrc0  <= ID_Valid ? ALUSrc0  : 1'b0;
                E_R_Enable <= ID_Valid ? R_Enable : 1'b0;
                E_W_Enable <= ID_Valid ? W_Enable : 1'b0;
                E_MemToReg <= ID_Valid ? MemToReg : 1'b0;
                E_RegWrite <= ID_Valid ? RegWrite : 1'b0;
                E_ALUSrc1  <= ID_Valid ? ALUSrc1  : 2'b00;
                E_R_Width  <= (ID_Valid && R_Enable) ? R_Width : 2'b00;
                E_W_Width  <= (ID_Valid && W_Enable) ? W_Width : 2'b00;
                E_Rs       <= Rs;
                E_Rt       <= Rt;
                E_Rd       <= Rd;
                E_Shamt    <= Shamt;
                E_Funct    <= Funct;
            end
        end
    end

`ifdef ID_EX_STATS_EN
    // A flush that coincides with a hazard counts only as a flush.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else if (!Hold) begin
            if (Flush) begin
                if (FlushCount != '1) FlushCount <= FlushCount + 1'b1;
            end else if (HazardStall) begin
                if (StallCount != '1) StallCount <= StallCount + 1'b1;
            end
        end
    end
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
